// File: rtl/shift_mix_seq_pkg.sv
// Shared types and field helpers for the ShiftRows / MixColumns round stage.
// Elements are redundant GF(2)[x] residues reduced by a runtime extended polynomial.
package shift_mix_seq_pkg;

  localparam int ELEM_W = 12;
  localparam int NCOL   = 4;

  typedef logic [ELEM_W-1:0] elem_t;
  typedef elem_t [3:0]       col_t;    // [r], row 0 in the low bits
  typedef col_t [NCOL-1:0]   state_t;  // [c][r], column-major

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  // Row r is rotated left by r columns.
  function automatic state_t shift_rows(input state_t s);
    state_t res;
    for (int c = 0; c < NCOL; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[c][r] = s[(c + r) % NCOL][r];
      end
    end
    return res;
  endfunction

  // Multiply by x; the polynomial's implicit top bit cancels the shifted-out bit.
  function automatic elem_t xtime(input elem_t a, input logic [ELEM_W:0] poly);
    logic [ELEM_W:0] t;
    t = {a, 1'b0} ^ (a[ELEM_W-1] ? poly : {(ELEM_W+1){1'b0}});
    return t[ELEM_W-1:0];
  endfunction

endpackage

// File: rtl/shift_mix_seq_mix_column_unit.sv
// Combinational MixColumns for one column of redundant field elements.
module mix_column_unit
  import shift_mix_seq_pkg::*;
(
  input  col_t              col_in,
  input  logic [ELEM_W:0]   mod_poly,
  output col_t              col_out
);

  col_t x2_s;

  // Each output row is 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3], indices mod 4
  always_comb begin
    x2_s    = '0;
    col_out = '0;
    for (int r = 0; r < 4; r++) begin
      x2_s[r] = xtime(col_in[r], mod_poly);
    end
    for (int r = 0; r < 4; r++) begin
      col_out[r] = x2_s[r] ^ x2_s[(r + 1) % 4] ^ col_in[(r + 1) % 4]
                 ^ col_in[(r + 2) % 4] ^ col_in[(r + 3) % 4];
    end
  end

endmodule

// File: rtl/shift_mix_seq.sv
// Round stage after sub-bytes: ShiftRows on capture, then MixColumns one column
// per cycle through a single shared column unit; result held until the next state.
module shift_mix_seq
  import shift_mix_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ELEM_W:0]      mod_poly,
  input  logic                 drdy_i,
  input  logic                 last_round,
  input  logic [16*ELEM_W-1:0] in,
  output logic [16*ELEM_W-1:0] out,
  output logic                 drdy_o,
  output logic                 busy,
  output logic                 overrun
);

  fsm_t       state_r;
  state_t     work_r;
  state_t     next_work_s;
  col_t       mixed_s;
  logic [1:0] col_r;
  logic       last_r;

  mix_column_unit u_mix (
    .col_in   (work_r[col_r]),
    .mod_poly (mod_poly),
    .col_out  (mixed_s)
  );

  // Work state with the current column replaced; the final round passes it through
  always_comb begin
    next_work_s = work_r;
    if (last_r) begin
      next_work_s[col_r] = work_r[col_r];
    end else begin
      next_work_s[col_r] = mixed_s;
    end
  end

  // Capture / column-sequencing FSM with registered status and result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      work_r  <= '0;
      col_r   <= 2'd0;
      last_r  <= 1'b0;
      out     <= '0;
      drdy_o  <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      drdy_o  <= 1'b0;
      overrun <= 1'b0;
      case (state_r)
        IDLE: begin
          if (drdy_i) begin
            work_r  <= shift_rows(in);
            last_r  <= last_round;
            col_r   <= 2'd0;
            busy    <= 1'b1;
            state_r <= RUN;
          end
        end
        RUN: begin
          work_r  <= next_work_s;
          col_r   <= col_r + 2'd1;
          overrun <= drdy_i;
          // Column 3 completes the state this cycle
          if (col_r == 2'd3) begin
            out     <= next_work_s;
            drdy_o  <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_mix_seq.sv
// Scoreboard bench: the reference model works in GF(2^8) mod 0x11B and the monitor
// reduces each redundant DUT element before comparing.
module tb_shift_mix_seq;

  localparam int W  = 12;
  localparam int SW = 16 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [W:0]    mod_poly;
  logic          drdy_i;
  logic          last_round;
  logic [SW-1:0] din;
  logic [SW-1:0] dout;
  logic          drdy_o;
  logic          busy;
  logic          overrun;

  typedef struct {
    logic [SW-1:0] raw;
    logic [127:0]  red;
    bit            last;
    int            due;
  } exp_t;

  exp_t sb_q[$];
  int   ovr_q[$];
  int   cyc      = 0;
  int   acc_cyc  = -100;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;

  shift_mix_seq dut (
    .clk        (clk),
    .rst        (rst),
    .mod_poly   (mod_poly),
    .drdy_i     (drdy_i),
    .last_round (last_round),
    .in         (din),
    .out        (dout),
    .drdy_o     (drdy_o),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] red8(input logic [11:0] v);
    logic [11:0] t;
    t = v;
    for (int b = 11; b >= 8; b--) begin
      if (t[b]) t = t ^ (12'h11B << (b - 8));
    end
    return t[7:0];
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input int r, input int k);
    case ((k - r + 4) % 4)
      0:       return 8'h02;
      1:       return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] red_state(input logic [SW-1:0] s);
    logic [127:0] res;
    for (int i = 0; i < 16; i++) res[i*8 +: 8] = red8(s[i*W +: W]);
    return res;
  endfunction

  // Random element congruent to a random byte: byte ^ (k * 0x11B), k < 16
  function automatic logic [11:0] rand_elem();
    logic [11:0] v;
    logic [3:0]  k;
    v = 12'($urandom_range(0, 255));
    k = 4'($urandom_range(0, 15));
    for (int j = 0; j < 4; j++) if (k[j]) v = v ^ (12'h11B << j);
    return v;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] s;
    for (int i = 0; i < 16; i++) s[i*W +: W] = rand_elem();
    return s;
  endfunction

  // Reference: AES ShiftRows, then the 2-3-1-1 matrix over GF(2^8)
  function automatic exp_t model(input logic [SW-1:0] st, input bit last);
    exp_t        e;
    logic [11:0] sh [4][4];
    logic [7:0]  a  [4];
    logic [7:0]  b;
    e.raw = '0; e.red = '0; e.last = last; e.due = 0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        sh[c][r] = st[(4*((c + r) % 4) + r)*W +: W];
        e.raw[(4*c + r)*W +: W] = sh[c][r];
      end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = red8(sh[c][r]);
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(coef(r, k), a[k]);
        e.red[(4*c + r)*8 +: 8] = b;
      end
    end
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [SW-1:0] st, input bit last);
    exp_t e;
    din = st; last_round = last; drdy_i = 1'b1;
    if (cyc >= acc_cyc + 1 && cyc <= acc_cyc + 4) begin
      ovr_q.push_back(cyc + 1);
    end else begin
      e = model(st, last);
      e.due = cyc + 5;
      sb_q.push_back(e);
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    drdy_i = 1'b0;
  endtask

  // Monitor: busy and overrun every cycle, result pops on each drdy_o pulse
  always @(negedge clk) begin
    bit   exp_busy;
    bit   exp_ovr;
    exp_t e;
    if (mon_en) begin
      exp_busy = (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + 4);
      check("busy", SW'(busy), SW'(exp_busy));
      exp_ovr = (ovr_q.size() > 0) && (ovr_q[0] == cyc);
      if (exp_ovr) void'(ovr_q.pop_front());
      if (overrun || exp_ovr) check("overrun", SW'(overrun), SW'(exp_ovr));
      if (drdy_o) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL drdy_o at cycle %0d: got pulse expected none pending", cyc);
        end else begin
          e = sb_q.pop_front();
          check("latency", SW'(cyc), SW'(e.due));
          if (e.last) check("state_sr", dout, e.raw);
          else        check("state_mc", SW'(red_state(dout)), SW'(e.red));
        end
      end
    end
  end

  initial begin
    logic [SW-1:0] st;
    logic [127:0]  rs;
    logic [7:0]    fips [4];
    fips[0] = 8'hdb; fips[1] = 8'h13; fips[2] = 8'h53; fips[3] = 8'h45;

    rst = 1'b1; drdy_i = 1'b0; last_round = 1'b0; din = '0; mod_poly = 13'h129D;
    idle(3);
    rst = 1'b0;
    check("reset_out", dout, '0);
    check("reset_drdy_o", SW'(drdy_o), '0);
    check("reset_busy", SW'(busy), '0);
    check("reset_overrun", SW'(overrun), '0);
    mon_en = 1'b1;
    idle(2);

    // FIPS column after ShiftRows lands in column 0: in[r][r] feeds work[0][r]
    st = '0;
    for (int i = 0; i < 16; i++) st[i*W +: W] = 12'($urandom_range(0, 255));
    for (int r = 0; r < 4; r++) st[(4*r + r)*W +: W] = {4'h0, fips[r]};
    issue(st, 1'b0);
    idle(4);
    rs = red_state(dout);
    check("fips_col0", SW'(rs[31:0]), SW'(32'hbca14d8e));

    // ShiftRows only, accepted back-to-back in the drdy_o cycle
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) st[(4*c + r)*W +: W] = 12'(16*c + r);
    issue(st, 1'b1);
    idle(4);
    check("sr_elem_1_3", SW'(dout[(4*1 + 3)*W +: W]), SW'(12'h003));
    check("sr_elem_2_1", SW'(dout[(4*2 + 1)*W +: W]), SW'(12'h031));

    // Random redundant states, back-to-back
    for (int i = 0; i < 8; i++) begin
      issue(rand_state(), ($urandom_range(0, 3) == 0));
      idle(4);
    end

    // Overrun: second drdy_i two cycles later is dropped
    issue(rand_state(), 1'b0);
    idle(1);
    issue(rand_state(), 1'b0);
    idle(6);

    // Reset in cycle N+2 aborts the state accepted in cycle N
    issue(rand_state(), 1'b0);
    idle(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    ovr_q.delete();
    acc_cyc = -100;
    check("midrst_out", dout, '0);
    check("midrst_busy", SW'(busy), '0);
    idle(1);
    issue(rand_state(), 1'b0);
    idle(10);

    check("sb_drained", SW'(sb_q.size()), '0);
    check("ovr_drained", SW'(ovr_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
